// File: rtl/pool_out_framer.sv
// pool_out_framer: tags pooled pixels with sof/eol/eof, buffers them in a FIFO with a registered
// output stage, and flags overflow/extra pixels. Define POOL_FRAMER_COORD_EN to add m_row/m_col outputs.
module pool_out_framer #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int DATA_WIDTH  = 8,
    parameter int CH_NUM      = 128,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [$clog2(FRAME_H_MAX):0]        out_h,
    input  logic [$clog2(FRAME_W_MAX):0]        out_w,
    input  logic                                frame_start,
    input  logic                                din_vld,
    input  logic [CH_NUM-1:0][DATA_WIDTH-1:0]   din,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [CH_NUM-1:0][DATA_WIDTH-1:0]   m_data,
    output logic                                m_sof,
    output logic                                m_eol,
    output logic                                m_eof,
    output logic                                frame_done,
    output logic                                overflow,
    output logic                                extra_pix
`ifdef POOL_FRAMER_COORD_EN
    ,
    output logic [$clog2(FRAME_H_MAX):0]        m_row,
    output logic [$clog2(FRAME_W_MAX):0]        m_col
`endif
);
    localparam int HW = $clog2(FRAME_H_MAX) + 1;
    localparam int WW = $clog2(FRAME_W_MAX) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2;

    logic [1:0] state;
    logic [HW-1:0] h_q, row, cur_h, cur_row;
    logic [WW-1:0] w_q, col, cur_w, cur_col;
    logic [PW-1:0] wr_ptr, rd_ptr, waddr;
    logic [CW-1:0] mem_cnt, total;
    logic [CH_NUM-1:0][DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [2:0] mem_tag [FIFO_DEPTH];
    logic start, pix, sof, eol, eof, pop, full, push, load;

    assign start   = frame_start && out_h != '0 && out_w != '0;
    assign cur_h   = start ? out_h : h_q;
    assign cur_w   = start ? out_w : w_q;
    assign cur_row = start ? '0 : row;
    assign cur_col = start ? '0 : col;
    assign pix     = din_vld && (start || state == ACTIVE);
    assign sof     = cur_row == '0 && cur_col == '0;
    assign eol     = cur_col == cur_w - WW'(1);
    assign eof     = eol && cur_row == cur_h - HW'(1);
    assign pop     = m_valid && m_ready;
    // Capacity includes the output register so the whole block holds exactly FIFO_DEPTH pixels.
    assign total   = mem_cnt + CW'(m_valid);
    assign full    = total == CW'(FIFO_DEPTH);
    assign push    = pix && (start || !full || pop);
    assign load    = !start && mem_cnt != '0 && (!m_valid || pop);
    assign waddr   = start ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[waddr] <= din;
            mem_tag[waddr]  <= {sof, eol, eof};
        end
    end

`ifdef POOL_FRAMER_COORD_EN
    logic [HW-1:0] mem_row [FIFO_DEPTH];
    logic [WW-1:0] mem_col [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_row[waddr] <= cur_row;
            mem_col[waddr] <= cur_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_row <= '0;
            m_col <= '0;
        end else if (load) begin
            m_row <= mem_row[rd_ptr];
            m_col <= mem_col[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            h_q        <= '0;
            w_q        <= '0;
            row        <= '0;
            col        <= '0;
            overflow   <= 1'b0;
            extra_pix  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (start) begin
                h_q <= out_h;
                w_q <= out_w;
            end
            if (pix) begin
                col <= eol ? '0 : cur_col + WW'(1);
                row <= eol ? cur_row + HW'(1) : cur_row;
            end else if (start) begin
                col <= '0;
                row <= '0;
            end
            overflow   <= (overflow && !start) || (pix && !push);
            extra_pix  <= !start && (extra_pix || (din_vld && state == DRAIN));
            frame_done <= !start && state == DRAIN && pop && m_eof;
            // An empty FIFO in DRAIN means the eof pixel was dropped.
            if (pix && eof)
                state <= DRAIN;
            else if (start)
                state <= ACTIVE;
            else if (state == DRAIN && ((pop && m_eof) || total == '0))
                state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (start) begin
            wr_ptr  <= PW'(push);
            rd_ptr  <= '0;
            mem_cnt <= CW'(push);
            m_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (load)
                rd_ptr <= rd_ptr + PW'(1);
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
            if (load) begin
                m_valid                <= 1'b1;
                m_data                 <= mem_data[rd_ptr];
                {m_sof, m_eol, m_eof}  <= mem_tag[rd_ptr];
            end else if (pop) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pool_out_framer.md
# pool_out_framer

Downstream stage of the pooling pipeline: consumes the per-pixel `dout_vld`/`dout` stream from the max-pool engine, tags each output pixel with start-of-frame, end-of-line and end-of-frame markers, and buffers it in a small FIFO. It presents the data on a valid/ready stream toward the memory writer or the next layer. The pooling engine cannot be stalled, so the block also detects and flags loss when the consumer applies backpressure for too long.

## Interface

Clocking and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `FRAME_H_MAX`, 224: max output frame height.
- `FRAME_W_MAX`, 224: max output frame width.
- `DATA_WIDTH`, 8: bits per channel.
- `CH_NUM`, 128: channels per pixel.
- `FIFO_DEPTH`, 16: pixel entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  async active-high reset.
- `out_h`  in  clog2(FRAME_H_MAX)+1  output frame height; sampled at `frame_start`.
- `out_w`  in  clog2(FRAME_W_MAX)+1  output frame width; sampled at `frame_start`.
- `frame_start`  in  1  one-cycle pulse that opens a frame.
- `din_vld`  in  1  pixel valid from the pool stage.
- `din`  in  CH_NUM×DATA_WIDTH  pooled pixel, packed `[CH_NUM-1:0][DATA_WIDTH-1:0]`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  CH_NUM×DATA_WIDTH  output pixel.
- `m_sof`  out  1  beat is pixel (0,0).
- `m_eol`  out  1  beat is the last column of its row.
- `m_eof`  out  1  beat is the last pixel of the frame.
- `frame_done`  out  1  one-cycle pulse when the `m_eof` beat transfers.
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full.
- `extra_pix`  out  1  sticky: `din_vld` arrived after the frame completed.

## Operation

- States: IDLE, ACTIVE, DRAIN. Reset puts the block in IDLE.
- IDLE:
  - `frame_start` with `out_h`≠0 and `out_w`≠0 latches the dimensions, clears `col`/`row`, `overflow` and `extra_pix`, and goes to ACTIVE.
  - `frame_start` with either dimension zero is ignored.
  - `din_vld` is ignored.
- ACTIVE:
  - Each `din_vld` is one pixel. Tags: `sof` = (row==0 && col==0); `eol` = (col==out_w-1); `eof` = eol && (row==out_h-1).
  - `col` increments and wraps to 0 at `out_w-1`; `row` increments on that wrap.
  - Counters advance even when the pixel is dropped, so tags on later pixels stay correct.
  - The pixel and its tags are pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the pixel is dropped and `overflow` sets.
  - The eof pixel, pushed or dropped, moves the block to DRAIN.
- DRAIN:
  - `din_vld` is ignored and sets `extra_pix`.
  - Return to IDLE on the cycle the eof beat pops (`frame_done`=1).
  - If the eof pixel was dropped, return to IDLE when the FIFO is empty; `frame_done` is not asserted.
- `frame_start` in ACTIVE or DRAIN: flush the FIFO (`m_valid` low next cycle), reload dimensions, clear counters and flags, go to ACTIVE. The aborted frame produces no `frame_done`.
- `frame_start` and `din_vld` in the same cycle: the pixel is (0,0) of the new frame.
- Output stream: a beat transfers on `m_valid && m_ready`. While `m_valid` is high, `m_data` and the tags hold stable until the transfer.
- Widths: `col`/`row` use the same widths as `out_w`/`out_h`; compare against `out_w-1`/`out_h-1` computed at full width. The FIFO count is clog2(FIFO_DEPTH)+1 bits.

## Timing

- Reset values: `m_valid`, `m_sof`, `m_eol`, `m_eof`, `frame_done`, `overflow`, `extra_pix` = 0; `m_data` = 0; FIFO empty.
- Latency: a pixel written into an empty FIFO at edge N gives `m_valid`=1 after edge N+1 (registered output, first-word fall-through).
- Throughput is one pixel per clock with `m_ready` held high; a full FIFO never drops in that case.
- `frame_done` is asserted in the cycle after the eof transfer edge, for one cycle.
- Sticky flags set in the cycle after the offending `din_vld` and are cleared only by reset or an accepted `frame_start`.

## Configuration

- `POOL_FRAMER_COORD_EN` defined: adds outputs `m_row` (clog2(FRAME_H_MAX)+1 bits) and `m_col` (clog2(FRAME_W_MAX)+1 bits). These are stored per FIFO entry, give the output coordinate of each beat, and reset to 0.
- Not defined: those ports and their FIFO storage do not exist. All other behaviour is identical.

## Test plan

- Frame 3×4 (h×w), `m_ready`=1, 12 consecutive pixels -> 12 beats, 1 cycle latency; `m_sof` on beat 0, `m_eol` on beats 3/7/11, `m_eof` on beat 11; one `frame_done`; flags 0.
- Frame 2×2, `m_ready`=0 for 20 cycles, `FIFO_DEPTH`=16, 4 pixels -> all 4 held and then delivered in order; `m_data` stable while stalled.
- Frame 5×5 (25 px), `m_ready`=0, `FIFO_DEPTH`=16 -> 16 stored, 9 dropped, `overflow`=1; `m_eof` never seen; after the drain the block returns to IDLE with no `frame_done`.
- Frame 2×3, after the 4th pixel a new `frame_start` with 1×2 -> FIFO flushed, next 2 beats tagged sof / eol+eof, one `frame_done`.
- Frame 1×1, then 2 extra `din_vld` -> one beat with sof+eol+eof, `extra_pix`=1.
- Assert `reset` mid-frame with the FIFO half full -> all outputs 0 immediately; a new 1×2 frame runs cleanly.
